// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared arena constants, cell codes, slot states and index helper
package bomb_pkg;

  localparam int GRID  = 10;
  localparam int CELLS = GRID * GRID;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BOMB  = 2'b01;
  localparam logic [1:0] CELL_FLAME = 2'b10;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_ARMED = 2'd1,
    SLOT_FLAME = 2'd2
  } slot_state_t;

  // Flattened map index; callers must only pass in-grid coordinates.
  function automatic logic [6:0] idx(input logic [3:0] x, input logic [3:0] y);
    return ({3'b000, x} * 7'd10) + {3'b000, y};
  endfunction

  function automatic logic in_grid(input logic [3:0] x, input logic [3:0] y);
    return (x < 4'd10) && (y < 4'd10);
  endfunction

endpackage

// File: rtl/bomb_manager_if.sv
// rtl/bomb_manager_if.sv - placement requests, arena/player inputs and bomb map outputs
interface bomb_manager_if;
  import bomb_pkg::*;

  logic             tick;
  logic             bombA_v;
  logic [3:0]       bombA_x;
  logic [3:0]       bombA_y;
  logic             bombB_v;
  logic [3:0]       bombB_x;
  logic [3:0]       bombB_y;
  logic [CELLS-1:0] onedim_Arena;
  logic [3:0]       playerAx;
  logic [3:0]       playerAy;
  logic [3:0]       playerBx;
  logic [3:0]       playerBy;
  logic [CELLS-1:0] Bomb_bit0;
  logic [CELLS-1:0] Bomb_bit1;
  logic             playerA_hit;
  logic             playerB_hit;

  modport master (
    output tick, bombA_v, bombA_x, bombA_y, bombB_v, bombB_x, bombB_y,
    output onedim_Arena, playerAx, playerAy, playerBx, playerBy,
    input  Bomb_bit0, Bomb_bit1, playerA_hit, playerB_hit
  );

  modport slave (
    input  tick, bombA_v, bombA_x, bombA_y, bombB_v, bombB_x, bombB_y,
    input  onedim_Arena, playerAx, playerAy, playerBx, playerBy,
    output Bomb_bit0, Bomb_bit1, playerA_hit, playerB_hit
  );

endinterface

// File: rtl/bomb_slot.sv
// rtl/bomb_slot.sv - one bomb slot: position plus IDLE/ARMED/FLAME fuse and flame timer
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS  = 3,
  parameter int FLAME_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [3:0]  load_x,
  input  logic [3:0]  load_y,
  input  logic        tick,
  input  logic        chain,
  output slot_state_t state,
  output logic [3:0]  x,
  output logic [3:0]  y
);

  slot_state_t state_n;
  logic [3:0]  counter, counter_n;
  logic [3:0]  x_n, y_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SLOT_IDLE;
      counter <= 4'd0;
      x       <= 4'd0;
      y       <= 4'd0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      x       <= x_n;
      y       <= y_n;
    end
  end

  // Chain ignition outranks the fuse tick so a bomb caught in flame never waits.
  always_comb begin
    state_n   = state;
    counter_n = counter;
    x_n       = x;
    y_n       = y;
    unique case (state)
      SLOT_IDLE: begin
        if (load) begin
          state_n   = SLOT_ARMED;
          counter_n = 4'(FUSE_TICKS);
          x_n       = load_x;
          y_n       = load_y;
        end
      end
      SLOT_ARMED: begin
        if (chain) begin
          state_n   = SLOT_FLAME;
          counter_n = 4'(FLAME_TICKS);
        end else if (tick) begin
          if (counter == 4'd1) begin
            state_n   = SLOT_FLAME;
            counter_n = 4'(FLAME_TICKS);
          end else begin
            counter_n = counter - 4'd1;
          end
        end
      end
      SLOT_FLAME: begin
        if (tick) begin
          if (counter == 4'd1) begin
            state_n   = SLOT_IDLE;
            counter_n = 4'd0;
          end else begin
            counter_n = counter - 4'd1;
          end
        end
      end
      default: begin
        state_n   = SLOT_IDLE;
        counter_n = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/bomb_manager.sv
// rtl/bomb_manager.sv - bomb slot allocation, registered bomb/flame map and player hit flags
module bomb_manager
  import bomb_pkg::*;
#(
  parameter int PER_PLAYER  = 2,
  parameter int FUSE_TICKS  = 3,
  parameter int FLAME_TICKS = 1,
  parameter int RANGE       = 2
) (
  input  logic          clk,
  input  logic          rst,
  bomb_manager_if.slave bus
);

  localparam int NSLOT = 2 * PER_PLAYER;

  slot_state_t      slot_state [NSLOT];
  logic [3:0]       slot_x     [NSLOT];
  logic [3:0]       slot_y     [NSLOT];
  logic [NSLOT-1:0] load;
  logic [NSLOT-1:0] chain;

  logic [CELLS-1:0] map_b0_q, map_b1_q;
  logic             hit_a_q, hit_b_q;

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    logic [3:0] lx, ly;
    if (s < PER_PLAYER) begin : g_a
      assign lx = bus.bombA_x;
      assign ly = bus.bombA_y;
    end else begin : g_b
      assign lx = bus.bombB_x;
      assign ly = bus.bombB_y;
    end

    assign chain[s] = map_b1_q[idx(slot_x[s], slot_y[s])];

    bomb_slot #(
      .FUSE_TICKS  (FUSE_TICKS),
      .FLAME_TICKS (FLAME_TICKS)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (load[s]),
      .load_x (lx),
      .load_y (ly),
      .tick   (bus.tick),
      .chain  (chain[s]),
      .state  (slot_state[s]),
      .x      (slot_x[s]),
      .y      (slot_y[s])
    );
  end

  logic             a_grid, b_grid, a_wall, b_wall, a_occ, b_occ;
  logic             a_found, b_found, a_ok, b_ok;
  logic [NSLOT-1:0] a_sel, b_sel;

  // Occupancy and free-slot search both look at the pre-edge slot table.
  always_comb begin
    a_grid  = in_grid(bus.bombA_x, bus.bombA_y);
    b_grid  = in_grid(bus.bombB_x, bus.bombB_y);
    a_wall  = a_grid ? bus.onedim_Arena[idx(bus.bombA_x, bus.bombA_y)] : 1'b0;
    b_wall  = b_grid ? bus.onedim_Arena[idx(bus.bombB_x, bus.bombB_y)] : 1'b0;
    a_occ   = 1'b0;
    b_occ   = 1'b0;
    a_found = 1'b0;
    b_found = 1'b0;
    a_sel   = '0;
    b_sel   = '0;
    for (int s = 0; s < NSLOT; s++) begin
      if (slot_state[s] != SLOT_IDLE) begin
        if (slot_x[s] == bus.bombA_x && slot_y[s] == bus.bombA_y) a_occ = 1'b1;
        if (slot_x[s] == bus.bombB_x && slot_y[s] == bus.bombB_y) b_occ = 1'b1;
      end
    end
    for (int s = 0; s < PER_PLAYER; s++) begin
      if (!a_found && slot_state[s] == SLOT_IDLE) begin
        a_sel[s] = 1'b1;
        a_found  = 1'b1;
      end
    end
    for (int s = PER_PLAYER; s < NSLOT; s++) begin
      if (!b_found && slot_state[s] == SLOT_IDLE) begin
        b_sel[s] = 1'b1;
        b_found  = 1'b1;
      end
    end
    a_ok = bus.bombA_v && a_grid && !a_wall && !a_occ && a_found;
    // A wins a same-cell tie; B sees the cell as taken.
    b_ok = bus.bombB_v && b_grid && !b_wall && !b_occ && b_found &&
           !(a_ok && bus.bombA_x == bus.bombB_x && bus.bombA_y == bus.bombB_y);
    load = ({NSLOT{a_ok}} & a_sel) | ({NSLOT{b_ok}} & b_sel);
  end

  logic [CELLS-1:0] bomb_n, flame_n;
  logic             blocked;
  logic [6:0]       ci;
  int               cx, cy;

  // Rays walk outward from the bomb and stop at the first wall or grid edge.
  always_comb begin
    bomb_n  = '0;
    flame_n = '0;
    blocked = 1'b0;
    ci      = 7'd0;
    cx      = 0;
    cy      = 0;
    for (int s = 0; s < NSLOT; s++) begin
      if (slot_state[s] == SLOT_ARMED) begin
        bomb_n[idx(slot_x[s], slot_y[s])] = 1'b1;
      end else if (slot_state[s] == SLOT_FLAME) begin
        flame_n[idx(slot_x[s], slot_y[s])] = 1'b1;
        for (int dir = 0; dir < 4; dir++) begin
          blocked = 1'b0;
          for (int d = 1; d <= RANGE; d++) begin
            cx = int'(slot_x[s]);
            cy = int'(slot_y[s]);
            case (dir)
              0:       cx = cx - d;
              1:       cx = cx + d;
              2:       cy = cy - d;
              default: cy = cy + d;
            endcase
            if (!blocked) begin
              if (cx < 0 || cx >= GRID || cy < 0 || cy >= GRID) begin
                blocked = 1'b1;
              end else begin
                ci = 7'(cx * GRID + cy);
                if (bus.onedim_Arena[ci]) blocked = 1'b1;
                else                      flame_n[ci] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_b0_q <= '0;
      map_b1_q <= '0;
      hit_a_q  <= 1'b0;
      hit_b_q  <= 1'b0;
    end else begin
      for (int i = 0; i < CELLS; i++) begin
        {map_b1_q[i], map_b0_q[i]} <= flame_n[i] ? CELL_FLAME :
                                      bomb_n[i]  ? CELL_BOMB  : CELL_EMPTY;
      end
      hit_a_q <= in_grid(bus.playerAx, bus.playerAy) ?
                 map_b1_q[idx(bus.playerAx, bus.playerAy)] : 1'b0;
      hit_b_q <= in_grid(bus.playerBx, bus.playerBy) ?
                 map_b1_q[idx(bus.playerBx, bus.playerBy)] : 1'b0;
    end
  end

  assign bus.Bomb_bit0   = map_b0_q;
  assign bus.Bomb_bit1   = map_b1_q;
  assign bus.playerA_hit = hit_a_q;
  assign bus.playerB_hit = hit_b_q;

endmodule

// File: tb/tb_bomb_manager.sv
// tb/tb_bomb_manager.sv - scoreboard bench for bomb_manager placement, flame, chain, hit and reset
module tb_bomb_manager;

  typedef struct {
    int         at;
    int         kind;
    logic [99:0] b1;
    logic [99:0] b0;
    logic       hit;
    string      tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    edge_n = 0;
  int    checks = 0;
  int    failures = 0;
  int    t;
  exp_t  sb[$];
  logic [99:0] fl33, fla, flb, fl11, fl15;

  bomb_manager_if bus();

  bomb_manager #(
    .PER_PLAYER  (2),
    .FUSE_TICKS  (3),
    .FLAME_TICKS (1),
    .RANGE       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [99:0] m(input int c0 = -1, input int c1 = -1, input int c2 = -1,
                                    input int c3 = -1, input int c4 = -1, input int c5 = -1,
                                    input int c6 = -1, input int c7 = -1, input int c8 = -1,
                                    input int c9 = -1);
    int a[10];
    logic [99:0] r;
    a = '{c0, c1, c2, c3, c4, c5, c6, c7, c8, c9};
    r = '0;
    for (int i = 0; i < 10; i++) if (a[i] >= 0) r[7'(a[i])] = 1'b1;
    return r;
  endfunction

  task automatic exp_map(input int at, input string tag, input logic [99:0] b1, input logic [99:0] b0);
    exp_t e;
    e.at = at; e.kind = 0; e.b1 = b1; e.b0 = b0; e.hit = 1'b0; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp_hit(input int at, input string tag, input int kind, input logic v);
    exp_t e;
    e.at = at; e.kind = kind; e.b1 = '0; e.b0 = '0; e.hit = v; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == edge_n) begin
        case (sb[i].kind)
          0:       check_eq(sb[i].tag, {bus.Bomb_bit1, bus.Bomb_bit0}, {sb[i].b1, sb[i].b0});
          1:       check_eq(sb[i].tag, {199'b0, bus.playerA_hit}, {199'b0, sb[i].hit});
          default: check_eq(sb[i].tag, {199'b0, bus.playerB_hit}, {199'b0, sb[i].hit});
        endcase
        sb.delete(i);
      end
    end
  end

  task automatic adv(input bit tk);
    bus.tick = tk;
    @(posedge clk);
    #1;
    bus.tick    = 1'b0;
    bus.bombA_v = 1'b0;
    bus.bombB_v = 1'b0;
  endtask

  task automatic pstep(input int base);
    adv(((edge_n + 1 - base) % 4) == 1);
  endtask

  task automatic req_a(input logic [3:0] x, input logic [3:0] y);
    bus.bombA_v = 1'b1; bus.bombA_x = x; bus.bombA_y = y;
  endtask

  task automatic req_b(input logic [3:0] x, input logic [3:0] y);
    bus.bombB_v = 1'b1; bus.bombB_x = x; bus.bombB_y = y;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog edge=%0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0;
    bus.bombA_v = 1'b0; bus.bombA_x = 4'd0; bus.bombA_y = 4'd0;
    bus.bombB_v = 1'b0; bus.bombB_x = 4'd0; bus.bombB_y = 4'd0;
    bus.onedim_Arena = '0;
    bus.playerAx = 4'd3; bus.playerAy = 4'd4;
    bus.playerBx = 4'd3; bus.playerBy = 4'd13;
    fl33 = m(33, 13, 23, 43, 53, 31, 32, 34, 35);
    fla  = m(24, 34, 44, 54, 64, 42, 43, 45, 46);
    flb  = m(26, 36, 46, 56, 66, 44, 45, 47, 48);
    fl11 = m(1, 11, 21, 31, 10, 12, 13);
    fl15 = m(5, 15, 25, 35, 13, 14, 16, 17);

    exp_map(2, "reset_map", '0, '0);
    exp_hit(2, "reset_hit_a", 1, 1'b0);
    exp_hit(2, "reset_hit_b", 2, 1'b0);
    repeat (3) adv(1'b0);
    rst = 1'b0;

    // single bomb, map lag, flame cross, hit on neighbour, out-of-grid player
    t = edge_n + 1;
    exp_map(t,      "s1_lag",        '0, '0);
    exp_map(t + 1,  "s1_armed",      '0, m(33));
    exp_map(t + 9,  "s1_armed_late", '0, m(33));
    exp_map(t + 10, "s1_flame",      fl33, '0);
    exp_map(t + 13, "s1_flame_end",  fl33, '0);
    exp_map(t + 14, "s1_clear",      '0, '0);
    exp_hit(t + 10, "s1_hit_a_pre",  1, 1'b0);
    exp_hit(t + 11, "s1_hit_a",      1, 1'b1);
    exp_hit(t + 11, "s1_hit_b_oob",  2, 1'b0);
    exp_hit(t + 15, "s1_hit_a_post", 1, 1'b0);
    req_a(4'd3, 4'd3);
    repeat (16) pstep(t);

    // wall at (0,2) stops the ray; corner bomb has no wrap; wall cell refused
    bus.onedim_Arena = m(2);
    t = edge_n + 1;
    exp_map(t + 1,  "s2_armed", '0, m(0));
    exp_map(t + 10, "s2_flame", m(0, 1, 10, 20), '0);
    exp_map(t + 14, "s2_clear", '0, '0);
    req_a(4'd0, 4'd0);
    req_b(4'd0, 4'd2);
    repeat (15) pstep(t);
    bus.onedim_Arena = '0;

    // chain: B bomb ignites from A flame before its own fuse ends
    t = edge_n + 1;
    exp_map(t + 3,  "s3_both_armed", '0, m(44, 46));
    exp_map(t + 9,  "s3_pre_flame",  '0, m(44, 46));
    exp_map(t + 10, "s3_a_flame",    fla, '0);
    exp_map(t + 11, "s3_chain_lag",  fla, '0);
    exp_map(t + 12, "s3_chain",      fla | flb, '0);
    exp_map(t + 14, "s3_clear",      '0, '0);
    req_a(4'd4, 4'd4);
    pstep(t);
    pstep(t);
    req_b(4'd4, 4'd6);
    repeat (14) pstep(t);

    // contention, duplicate, out-of-range requests and per-player exhaustion
    t = edge_n + 1;
    exp_map(t + 1, "s4_contend",   '0, m(55));
    exp_map(t + 2, "s4_dup_drop",  '0, m(55));
    exp_map(t + 3, "s4_b_first",   '0, m(55, 77));
    exp_map(t + 4, "s4_b_second",  '0, m(55, 77, 88));
    exp_map(t + 5, "s4_b_full",    '0, m(55, 77, 88));
    exp_map(t + 6, "s4_a_second",  '0, m(55, 77, 88, 66));
    exp_map(t + 7, "s4_a_full",    '0, m(55, 77, 88, 66));
    exp_map(t + 12, "s4_clear",    '0, '0);
    req_a(4'd5, 4'd5); req_b(4'd5, 4'd5); adv(1'b0);
    req_a(4'd5, 4'd5); req_b(4'd10, 4'd1); adv(1'b0);
    req_b(4'd7, 4'd7); req_a(4'd2, 4'd12); adv(1'b0);
    req_b(4'd8, 4'd8); adv(1'b0);
    req_b(4'd2, 4'd2); adv(1'b0);
    req_a(4'd6, 4'd6); adv(1'b0);
    req_a(4'd6, 4'd7); adv(1'b0);
    adv(1'b0);
    repeat (4) adv(1'b1);
    adv(1'b0);

    // exhaustion then reuse of slot 0 only once it is idle before the edge
    t = edge_n + 1;
    exp_map(t + 4,  "s5_third_drop",  '0, m(11, 15));
    exp_map(t + 10, "s5_first_flame", fl11, m(15));
    exp_map(t + 14, "s5_same_edge",   fl15, '0);
    exp_map(t + 15, "s5_reuse",       fl15, m(71));
    exp_map(t + 18, "s5_reuse_armed", '0, m(71));
    exp_map(t + 30, "s5_clear",       '0, '0);
    req_a(4'd1, 4'd1); pstep(t);
    pstep(t);
    req_a(4'd1, 4'd5); pstep(t);
    req_a(4'd7, 4'd1); pstep(t);
    repeat (9) pstep(t);
    req_a(4'd7, 4'd1); pstep(t);
    req_a(4'd7, 4'd1); pstep(t);
    repeat (16) pstep(t);

    // reset while one bomb is burning and another is armed
    t = edge_n + 1;
    exp_map(t + 10, "s6_flame",      fl33, m(88));
    exp_hit(t + 11, "s6_hit_a",      1, 1'b1);
    exp_map(t + 12, "s6_rst_map",    '0, '0);
    exp_hit(t + 12, "s6_rst_hit_a",  1, 1'b0);
    exp_map(t + 14, "s6_no_flame",   '0, '0);
    exp_map(t + 18, "s6_no_flame2",  '0, '0);
    req_a(4'd3, 4'd3); pstep(t);
    pstep(t);
    req_b(4'd8, 4'd8); pstep(t);
    repeat (9) pstep(t);
    rst = 1'b1; pstep(t);
    rst = 1'b0;
    repeat (6) pstep(t);

    repeat (2) adv(1'b0);
    check_eq("sb_drained", 200'(sb.size()), 200'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
